// File: rtl/multi_digit_countdown_timer_pkg.sv
// multi_digit_countdown_timer_pkg: shared state encoding, segment constants and BCD decode
package timer_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Active-low segments, bit0 = a .. bit6 = g; non-decimal codes show blank
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: bcd_to_seg = 7'h40;
      4'd1: bcd_to_seg = 7'h79;
      4'd2: bcd_to_seg = 7'h24;
      4'd3: bcd_to_seg = 7'h30;
      4'd4: bcd_to_seg = 7'h19;
      4'd5: bcd_to_seg = 7'h12;
      4'd6: bcd_to_seg = 7'h02;
      4'd7: bcd_to_seg = 7'h78;
      4'd8: bcd_to_seg = 7'h00;
      4'd9: bcd_to_seg = 7'h10;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/multi_digit_countdown_timer_if.sv
// multi_digit_countdown_timer_if: control strobes from the game FSM and timer/display outputs
interface multi_digit_countdown_timer_if #(
  parameter int NUM_DIGITS = 2
);

  logic                    Clear;
  logic                    Load;
  logic                    Start;
  logic                    Pause;
  logic [4*NUM_DIGITS-1:0] StartBCD;
  logic [4*NUM_DIGITS-1:0] CountBCD;
  logic                    Running;
  logic                    Expired;
  logic                    Done;
  logic [7*NUM_DIGITS-1:0] Hex;

  modport master (
    output Clear, Load, Start, Pause, StartBCD,
    input  CountBCD, Running, Expired, Done, Hex
  );

  modport slave (
    input  Clear, Load, Start, Pause, StartBCD,
    output CountBCD, Running, Expired, Done, Hex
  );

endinterface

// File: rtl/multi_digit_countdown_timer_bcd_down_digit.sv
// bcd_down_digit: one decade down-counter with clamped load, clear and borrow chaining
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       ClockIn,
  input  logic       ResetN,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_borrow_in,
  output logic       o_borrow_out,
  output logic [3:0] o_digit
);

  logic [3:0] r_digit;

  always_ff @(posedge ClockIn or negedge ResetN)
    if (!ResetN) r_digit <= 4'd0;
    else if (i_clear) r_digit <= 4'd0;
    else if (i_load) r_digit <= (i_load_val > DIGIT_MAX) ? DIGIT_MAX : i_load_val;
    else if (i_borrow_in) r_digit <= (r_digit == 4'd0) ? DIGIT_MAX : r_digit - 4'd1;

  assign o_borrow_out = i_borrow_in && (r_digit == 4'd0);
  assign o_digit      = r_digit;

endmodule

// File: rtl/multi_digit_countdown_timer.sv
// multi_digit_countdown_timer: prescaled BCD countdown with run/pause/expire FSM and
// seven-segment driver with leading-zero blanking and expiry blink
module multi_digit_countdown_timer
  import timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int NUM_DIGITS      = 2,
  parameter int BLINK_PERIOD    = 25000000
) (
  input logic                         ClockIn,
  input logic                         ResetN,
  multi_digit_countdown_timer_if.slave bus
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(CLOCK_FREQUENCY);
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLOCK_FREQUENCY - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIOD - 1);

  state_t              r_state, w_next;
  logic [PW-1:0]       r_pre, w_pre_next;
  logic [BW-1:0]       r_blink;
  logic                r_phase;
  logic                r_done;
  logic [CW-1:0]       w_count;
  logic [NUM_DIGITS:0] w_borrow;
  logic                w_unused;
  logic                w_ctrl;
  logic                w_dec;
  logic                w_one;
  logic                w_start;
  logic                w_stay_exp;
  logic                w_blink_wrap;
  logic [7*NUM_DIGITS-1:0] w_hex;

  assign w_ctrl       = bus.Clear || bus.Load;
  assign w_dec        = (r_state == S_RUN) && !bus.Pause && (r_pre == '0) && !w_ctrl;
  assign w_one        = (w_count == CW'(1));
  assign w_start      = (r_state == S_IDLE) && bus.Start && (w_count != '0);
  assign w_stay_exp   = (r_state == S_EXPIRED) && (w_next == S_EXPIRED);
  assign w_blink_wrap = (r_blink == BLINK_MAX);
  assign w_borrow[0]  = w_dec;
  // The top digit never borrows: RUN is only entered with a nonzero count
  assign w_unused     = w_borrow[NUM_DIGITS];

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_down_digit u_digit (
        .ClockIn      (ClockIn),
        .ResetN       (ResetN),
        .i_clear      (bus.Clear),
        .i_load       (bus.Load),
        .i_load_val   (bus.StartBCD[4*i +: 4]),
        .i_borrow_in  (w_borrow[i]),
        .o_borrow_out (w_borrow[i+1]),
        .o_digit      (w_count[4*i +: 4])
      );
      // Digit i>0 is lit only when it or some higher digit is nonzero
      assign w_hex[7*i +: 7] = (r_state == S_EXPIRED) ? (r_phase ? SEG_BLANK : bcd_to_seg(4'd0))
                             : (i == 0 || |w_count[CW-1:4*i]) ? bcd_to_seg(w_count[4*i +: 4])
                             : SEG_BLANK;
    end
  endgenerate

  always_comb begin
    w_next     = r_state;
    w_pre_next = r_pre;
    if (w_ctrl) begin
      w_next     = S_IDLE;
      w_pre_next = PRE_MAX;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next     = w_start ? S_RUN : S_IDLE;
          w_pre_next = w_start ? PRE_MAX : r_pre;
        end
        S_RUN: begin
          w_next     = bus.Pause ? S_PAUSED : (w_dec && w_one) ? S_EXPIRED : S_RUN;
          w_pre_next = bus.Pause ? r_pre : w_dec ? PRE_MAX : r_pre - PW'(1);
        end
        S_PAUSED: w_next = bus.Pause ? S_PAUSED : S_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ClockIn or negedge ResetN)
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_pre   <= PRE_MAX;
      r_blink <= '0;
      r_phase <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pre   <= w_pre_next;
      r_done  <= (r_state == S_RUN) && (w_next == S_EXPIRED);
      r_blink <= (w_stay_exp && !w_blink_wrap) ? r_blink + BW'(1) : '0;
      r_phase <= w_stay_exp ? r_phase ^ w_blink_wrap : 1'b0;
    end

  assign bus.CountBCD = w_count;
  assign bus.Running  = (r_state == S_RUN);
  assign bus.Expired  = (r_state == S_EXPIRED);
  assign bus.Done     = r_done;
  assign bus.Hex      = ResetN ? w_hex : '1;

endmodule

// File: tb/tb_multi_digit_countdown_timer.sv
// tb_multi_digit_countdown_timer: directed + randomized checks against a decimal-arithmetic model
module tb_multi_digit_countdown_timer;

  localparam int CF = 4, N = 2, BP = 3, W = 4 * N, HW = 7 * N;
  localparam int IDLE = 0, RUN = 1, PAUSED = 2, EXP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_digit_countdown_timer_if #(.NUM_DIGITS(N)) bus ();

  multi_digit_countdown_timer #(
    .CLOCK_FREQUENCY (CF),
    .NUM_DIGITS      (N),
    .BLINK_PERIOD    (BP)
  ) dut (
    .ClockIn (clk),
    .ResetN  (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0, n_bad = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int m_val = 0, m_st = IDLE, m_left = CF, m_exp = 0;
  bit m_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampval(input logic [W-1:0] b);
    int v = 0, p = 1;
    for (int k = 0; k < N; k++) begin
      int d = int'(b[4*k +: 4]);
      v += (d > 9 ? 9 : d) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] exp_bcd(input int v);
    logic [W-1:0] r = '0;
    int p = 1;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [HW-1:0] exp_hex();
    logic [HW-1:0] r = '1;
    int p = 1;
    if (!rst_n) return r;
    for (int k = 0; k < N; k++) begin
      if (m_st == EXP) r[7*k +: 7] = ((m_exp / BP) % 2) ? 7'h7F : 7'h40;
      else r[7*k +: 7] = (k == 0 || m_val >= p) ? seg_tab[(m_val / p) % 10] : 7'h7F;
      p *= 10;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_val = 0; m_st = IDLE; m_left = CF; m_exp = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.Clear) begin
        m_val = 0; m_st = IDLE; m_left = CF;
      end else if (bus.Load) begin
        m_val = clampval(bus.StartBCD); m_st = IDLE; m_left = CF;
      end else begin
        case (m_st)
          IDLE: if (bus.Start && m_val != 0) begin m_st = RUN; m_left = CF; end
          RUN: if (bus.Pause) m_st = PAUSED;
               else begin
                 m_left--;
                 if (m_left == 0) begin
                   m_left = CF;
                   m_val--;
                   if (m_val == 0) begin m_st = EXP; m_done = 1'b1; m_exp = 0; end
                 end
               end
          PAUSED: if (!bus.Pause) m_st = RUN;
          default: m_exp++;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("count", bus.CountBCD, exp_bcd(m_val));
    chk("hex", bus.Hex, exp_hex());
    chk("running", bus.Running, m_st == RUN);
    chk("expired", bus.Expired, m_st == EXP);
    chk("done", bus.Done, m_done);
  end

  task automatic step(input logic c, input logic l, input logic [W-1:0] b, input logic s, input logic p);
    @(negedge clk);
    bus.Clear = c; bus.Load = l; bus.StartBCD = b; bus.Start = s; bus.Pause = p;
  endtask

  initial begin
    int lat;
    bit seen9;
    logic pz;
    bus.Clear = 0; bus.Load = 0; bus.StartBCD = '0; bus.Start = 0; bus.Pause = 0;
    repeat (2) @(negedge clk);
    chk("rst_hex", bus.Hex, 14'h3FFF);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("idle_hex", bus.Hex, 14'h3FC0);

    // Full countdown from 25, expiry, blink and clear
    step(0, 1, 8'h25, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("load_25", bus.CountBCD, 8'h25);
    lat = -1; seen9 = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      step(0, 0, 0, 0, 0);
      if (!seen9 && bus.CountBCD == 8'h09) begin
        seen9 = 1'b1;
        chk("tens_blank", bus.Hex, 14'h3F90);
      end
      if (bus.Done) begin lat = k - 1; break; end
    end
    chk("done_latency", lat, 100);
    chk("seen_09", seen9, 1);
    chk("exp_visible", bus.Hex, 14'h2040);
    for (int j = 1; j <= 5; j++) begin
      step(0, 0, 0, 1, 1);
      chk("blink", bus.Hex, (j < 3) ? 14'h2040 : 14'h3FFF);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("clear_hex", bus.Hex, 14'h3FC0);
    chk("clear_expired", bus.Expired, 0);

    // Pause with a partial prescaler interval
    step(0, 1, 8'h12, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int j = 0; j < 9; j++) begin
      step(0, 0, 0, 0, 1);
      chk("pause_count", bus.CountBCD, 8'h12);
      chk("pause_running", bus.Running, 0);
    end
    step(0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0, 0, 0);
      chk("resume_hold", bus.CountBCD, 8'h12);
    end
    step(0, 0, 0, 0, 0);
    chk("resume_dec", bus.CountBCD, 8'h11);

    // Start with zero count
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0, 0, 0);
      chk("zero_running", bus.Running, 0);
      chk("zero_done", bus.Done, 0);
      chk("zero_hex", bus.Hex, 14'h3FC0);
    end

    // Load clamping and control priority
    step(0, 1, 8'hA3, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("load_clamp", bus.CountBCD, 8'h93);
    step(0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 1, 8'h07, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("load_in_run", bus.CountBCD, 8'h07);
    chk("load_in_run_state", bus.Running, 0);
    step(1, 1, 8'h55, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("clear_over_load", bus.CountBCD, 8'h00);

    // Asynchronous reset mid-RUN
    step(0, 1, 8'h25, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hex", bus.Hex, 14'h3FFF);
    chk("async_running", bus.Running, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("post_rst_count", bus.CountBCD, 8'h00);
    chk("post_rst_done", bus.Done, 0);

    // Randomized control traffic
    pz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] b;
      b[7:4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 1));
      b[3:0] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) pz = ~pz;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0, b, $urandom_range(0, 4) == 0, pz);
    end
    repeat (2) step(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
